pong_match_ctrl: RTL and testbench

Match sequencer for the pong game. It sits between `hvsync_generator` and `pong`. It decides when the ball may move and when it is re-centred, and keeps both players' scores and the win condition. All game time is counted in frames, derived from the `vsync` edge, so pacing stays the same whatever the pixel clock is.

---
 rtl/pong_pkg.sv | 33 +++
 rtl/frame_timer.sv | 48 ++++
 rtl/pong_match_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pong_match_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong match sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pong_pkg;

  // Match phases; the sequencer walks IDLE -> SERVE -> PLAY -> POINT -> (SERVE | OVER).
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } match_state_t;

  // Scores are plain 4-bit binary, enough for any win score up to 15.
  localparam int SCORE_W = 4;

  // Launch direction encoding seen by pong.
  localparam logic SERVE_LEFT  = 1'b0;
  localparam logic SERVE_RIGHT = 1'b1;

  // Score increment that holds at all-ones instead of wrapping to zero.
  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
    logic [SCORE_W-1:0] r;
    if (s == {SCORE_W{1'b1}}) begin
      r = s;
    end else begin
      r = s + 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame pacing: vsync rising-edge detect plus a loadable frame down-counter.
// Latency: frame_tick is high the cycle after vsync is first seen high; expired follows the count register.
// Backpressure: none; vsync is free-running and the counter is reloaded at will by the owner.
module frame_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             vsync,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             frame_tick,
  output logic             expired
);

  logic             vsync_q;
  logic             armed;
  logic [CNT_W-1:0] cnt_q;

  // Edge detect. 'armed' stays low until vsync has been seen low once, so a vsync
  // already high when reset is released cannot masquerade as a fresh frame start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q    <= 1'b0;
      armed      <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vsync_q    <= vsync;
      armed      <= armed | ~vsync;
      frame_tick <= vsync & ~vsync_q & armed;
    end
  end

  // Down-counter: a load wins over a tick; the count parks at zero until reloaded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (frame_tick && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // A load of N therefore spans N+1 ticks: N decrements, then the tick seen at zero.
  assign expired = (cnt_q == '0);

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve/play/point pacing in frames, score keeping and win detection.
// Latency: all outputs registered; a miss or frame event shows on the outputs one cycle later.
// Backpressure: none; inputs are level/pulse signals sampled every cycle, nothing is ever stalled.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30,
  parameter int WIN_SCORE    = 11
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               vsync,
  input  logic               start,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic               ball_run,
  output logic               ball_load,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               game_over,
  output logic               winner
);

  // Counter is sized for the longer of the two waits.
  localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_W      = (MAX_FRAMES < 1) ? 1 : $clog2(MAX_FRAMES + 1);

  localparam logic [CNT_W-1:0]   SERVE_LD = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0]   POINT_LD = CNT_W'(POINT_FRAMES);
  localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);

  match_state_t       state_q, state_d;
  logic [SCORE_W-1:0] score1_q, score1_d;
  logic [SCORE_W-1:0] score2_q, score2_d;
  logic               dir_q, dir_d;
  logic               start_q;
  logic               press;
  logic               load_pulse;
  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_val;
  logic               frame_tick;
  logic               expired;

  frame_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .vsync      (vsync),
    .load       (cnt_load),
    .load_val   (cnt_val),
    .frame_tick (frame_tick),
    .expired    (expired)
  );

  // The start button is only looked at once per frame, which also debounces it;
  // a press is a 0 -> 1 change between consecutive frame samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_q <= 1'b0;
    end else if (frame_tick) begin
      start_q <= start;
    end
  end

  assign press = frame_tick & start & ~start_q;

  // State, scores and serve direction registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      score1_q <= '0;
      score2_q <= '0;
      dir_q    <= SERVE_LEFT;
    end else begin
      state_q  <= state_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      dir_q    <= dir_d;
    end
  end

  // Next-state, scoring and counter-load decisions.
  always_comb begin
    state_d    = state_q;
    score1_d   = score1_q;
    score2_d   = score2_q;
    dir_d      = dir_q;
    load_pulse = 1'b0;
    cnt_load   = 1'b0;
    cnt_val    = SERVE_LD;

    unique case (state_q)
      // A finished match restarts exactly like a fresh one.
      ST_IDLE, ST_OVER: begin
        if (press) begin
          score1_d   = '0;
          score2_d   = '0;
          dir_d      = SERVE_LEFT;
          load_pulse = 1'b1;
          cnt_load   = 1'b1;
          cnt_val    = SERVE_LD;
          state_d    = ST_SERVE;
        end
      end

      ST_SERVE: begin
        if (frame_tick && expired) begin
          state_d = ST_PLAY;
        end
      end

      // Leaving PLAY on the first miss cycle is what keeps a held miss from scoring twice.
      ST_PLAY: begin
        if (miss_left || miss_right) begin
          state_d  = ST_POINT;
          cnt_load = 1'b1;
          cnt_val  = POINT_LD;
          if (miss_left && !miss_right) begin
            score2_d = score_inc(score2_q);
            dir_d    = SERVE_LEFT;
          end else if (miss_right && !miss_left) begin
            score1_d = score_inc(score1_q);
            dir_d    = SERVE_RIGHT;
          end
        end
      end

      // The win check sits here, so a score can never step past the win score.
      ST_POINT: begin
        if (frame_tick && expired) begin
          if ((score1_q == WIN_VAL) || (score2_q == WIN_VAL)) begin
            state_d = ST_OVER;
          end else begin
            load_pulse = 1'b1;
            cnt_load   = 1'b1;
            cnt_val    = SERVE_LD;
            state_d    = ST_SERVE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered outputs decoded from the next state, so they line up with the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ball_run  <= 1'b0;
      ball_load <= 1'b0;
      game_over <= 1'b0;
      winner    <= 1'b0;
    end else begin
      ball_run  <= (state_d == ST_PLAY);
      ball_load <= load_pulse;
      game_over <= (state_d == ST_OVER);
      winner    <= (state_d == ST_OVER) && (score2_d == WIN_VAL);
    end
  end

  assign score1    = score1_q;
  assign score2    = score2_q;
  assign serve_dir = dir_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: directed table, multi-cycle corner sequences, then random play
// checked every cycle against a frame-level reference model.
module tb_pong_match_ctrl;

  localparam int S = 2;
  localparam int P = 3;
  localparam int W = 3;

  localparam int OP_FRM = 0;
  localparam int OP_STA = 1;
  localparam int OP_MIS = 2;

  localparam int M_IDLE  = 0;
  localparam int M_SERVE = 1;
  localparam int M_PLAY  = 2;
  localparam int M_POINT = 3;
  localparam int M_OVER  = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       vsync;
  logic       start;
  logic       miss_left;
  logic       miss_right;
  logic       ball_run;
  logic       ball_load;
  logic       serve_dir;
  logic [3:0] score1;
  logic [3:0] score2;
  logic       game_over;
  logic       winner;

  int errors = 0;
  int checks = 0;
  int loads_seen = 0;

  // Reference model: phase, ticks still to wait, scores, direction.
  int m_phase;
  int m_left;
  int m_s1;
  int m_s2;
  bit m_dir;
  bit m_load;
  bit m_tick;
  bit m_vs_prev;
  bit m_st_prev;

  typedef struct {
    string nm;
    int    op;
    int    n;
    bit    ml;
    bit    mr;
    bit    e_run;
    bit    e_dir;
    int    e_s1;
    int    e_s2;
    bit    e_over;
    bit    e_win;
    int    e_loads;
  } vec_t;

  vec_t tbl[$];

  pong_match_ctrl #(
    .SERVE_FRAMES (S),
    .POINT_FRAMES (P),
    .WIN_SCORE    (W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .vsync      (vsync),
    .start      (start),
    .miss_left  (miss_left),
    .miss_right (miss_right),
    .ball_run   (ball_run),
    .ball_load  (ball_load),
    .serve_dir  (serve_dir),
    .score1     (score1),
    .score2     (score2),
    .game_over  (game_over),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL timeout: bench did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [12:0] dut_vec();
    return {ball_run, ball_load, serve_dir, score1, score2, game_over, winner};
  endfunction

  function automatic logic [12:0] model_vec();
    logic r, o, w;
    r = (m_phase == M_PLAY);
    o = (m_phase == M_OVER);
    w = o && (m_s2 == W);
    return {r, m_load, m_dir, 4'(m_s1), 4'(m_s2), o, w};
  endfunction

  // A vsync that is high out of reset must first fall, so treat the pre-reset level as high.
  task automatic model_reset();
    m_phase   = M_IDLE;
    m_left    = 0;
    m_s1      = 0;
    m_s2      = 0;
    m_dir     = 1'b0;
    m_load    = 1'b0;
    m_tick    = 1'b0;
    m_vs_prev = 1'b1;
    m_st_prev = 1'b0;
  endtask

  task automatic model_step();
    bit tick, press;
    if (!reset_n) begin
      model_reset();
      return;
    end
    tick   = m_tick;
    m_load = 1'b0;
    press  = tick && start && !m_st_prev;
    if (tick) m_st_prev = start;
    case (m_phase)
      M_IDLE, M_OVER: begin
        if (press) begin
          m_s1 = 0; m_s2 = 0; m_dir = 1'b0; m_load = 1'b1;
          m_left = S + 1; m_phase = M_SERVE;
        end
      end
      M_SERVE: begin
        if (tick) begin
          m_left--;
          if (m_left == 0) m_phase = M_PLAY;
        end
      end
      M_PLAY: begin
        if (miss_left || miss_right) begin
          if (miss_left && !miss_right) begin
            if (m_s2 < 15) m_s2++;
            m_dir = 1'b0;
          end else if (miss_right && !miss_left) begin
            if (m_s1 < 15) m_s1++;
            m_dir = 1'b1;
          end
          m_left  = P + 1;
          m_phase = M_POINT;
        end
      end
      M_POINT: begin
        if (tick) begin
          m_left--;
          if (m_left == 0) begin
            if (m_s1 == W || m_s2 == W) begin
              m_phase = M_OVER;
            end else begin
              m_load = 1'b1; m_left = S + 1; m_phase = M_SERVE;
            end
          end
        end
      end
      default: ;
    endcase
    m_tick    = vsync && !m_vs_prev;
    m_vs_prev = vsync;
  endtask

  // One clock: model advances on the edge, DUT is compared on the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (ball_load === 1'b1) loads_seen++;
    check("model", {3'b0, dut_vec()}, {3'b0, model_vec()});
  endtask

  task automatic run_frame();
    vsync = 1'b1;
    cyc();
    cyc();
    vsync = 1'b0;
    repeat (6) cyc();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) cyc();
    reset_n = 1'b1;
    repeat (2) cyc();
  endtask

  task automatic add(input string nm, input int op, input int n, input bit ml, input bit mr,
                     input bit e_run, input bit e_dir, input int e_s1, input int e_s2,
                     input bit e_over, input bit e_win, input int e_loads);
    vec_t v;
    v.nm = nm; v.op = op; v.n = n; v.ml = ml; v.mr = mr;
    v.e_run = e_run; v.e_dir = e_dir; v.e_s1 = e_s1; v.e_s2 = e_s2;
    v.e_over = e_over; v.e_win = e_win; v.e_loads = e_loads;
    tbl.push_back(v);
  endtask

  initial begin
    int hi, lo;
    reset_n    = 1'b0;
    vsync      = 1'b0;
    start      = 1'b0;
    miss_left  = 1'b0;
    miss_right = 1'b0;
    model_reset();

    // Directed table: name, op, count, miss_l, miss_r | run, dir, s1, s2, over, win, loads
    add("idle5",       OP_FRM, 5,  0, 0,  0, 0, 0, 0, 0, 0, 0);
    add("start1",      OP_STA, 1,  0, 0,  0, 0, 0, 0, 0, 0, 1);
    add("serve2",      OP_FRM, 2,  0, 0,  0, 0, 0, 0, 0, 0, 0);
    add("serve3",      OP_FRM, 1,  0, 0,  1, 0, 0, 0, 0, 0, 0);
    add("missr_hold",  OP_MIS, 10, 0, 1,  0, 1, 1, 0, 0, 0, 0);
    add("point3",      OP_FRM, 3,  0, 0,  0, 1, 1, 0, 0, 0, 0);
    add("point4",      OP_FRM, 1,  0, 0,  0, 1, 1, 0, 0, 0, 1);
    add("serve_p1",    OP_FRM, 3,  0, 0,  1, 1, 1, 0, 0, 0, 0);
    add("miss_both",   OP_MIS, 1,  1, 1,  0, 1, 1, 0, 0, 0, 0);
    add("replay_srv",  OP_FRM, 4,  0, 0,  0, 1, 1, 0, 0, 0, 1);
    add("replay_play", OP_FRM, 3,  0, 0,  1, 1, 1, 0, 0, 0, 0);
    add("missl_1",     OP_MIS, 1,  1, 0,  0, 0, 1, 1, 0, 0, 0);
    add("cycle_1",     OP_FRM, 7,  0, 0,  1, 0, 1, 1, 0, 0, 1);
    add("missl_2",     OP_MIS, 1,  1, 0,  0, 0, 1, 2, 0, 0, 0);
    add("cycle_2",     OP_FRM, 7,  0, 0,  1, 0, 1, 2, 0, 0, 1);
    add("missl_3",     OP_MIS, 1,  1, 0,  0, 0, 1, 3, 0, 0, 0);
    add("over",        OP_FRM, 4,  0, 0,  0, 0, 1, 3, 1, 1, 0);
    add("over_miss",   OP_MIS, 3,  1, 0,  0, 0, 1, 3, 1, 1, 0);
    add("restart",     OP_STA, 1,  0, 0,  0, 0, 0, 0, 0, 0, 1);

    repeat (2) cyc();
    check("reset_outputs", {3'b0, dut_vec()}, 16'h0000);
    reset_n = 1'b1;
    repeat (3) cyc();

    foreach (tbl[k]) begin
      vec_t v;
      v = tbl[k];
      loads_seen = 0;
      if (v.op == OP_FRM) begin
        repeat (v.n) run_frame();
      end else if (v.op == OP_STA) begin
        start = 1'b1;
        run_frame();
        start = 1'b0;
      end else begin
        miss_left  = v.ml;
        miss_right = v.mr;
        cyc();
        check($sformatf("%s_next", v.nm), {7'd0, ball_run, score1, score2},
              {7'd0, 1'b0, 4'(v.e_s1), 4'(v.e_s2)});
        repeat (v.n - 1) cyc();
        miss_left  = 1'b0;
        miss_right = 1'b0;
        cyc();
      end
      check($sformatf("%s_run", v.nm),   16'(ball_run),   16'(v.e_run));
      check($sformatf("%s_dir", v.nm),   16'(serve_dir),  16'(v.e_dir));
      check($sformatf("%s_s1", v.nm),    16'(score1),     16'(v.e_s1));
      check($sformatf("%s_s2", v.nm),    16'(score2),     16'(v.e_s2));
      check($sformatf("%s_over", v.nm),  16'(game_over),  16'(v.e_over));
      check($sformatf("%s_win", v.nm),   16'(winner),     16'(v.e_win));
      check($sformatf("%s_loads", v.nm), 16'(loads_seen), 16'(v.e_loads));
    end

    // Reset mid-SERVE with the counter at 1, after a point so outputs are non-zero.
    repeat (3) run_frame();
    miss_right = 1'b1;
    cyc();
    miss_right = 1'b0;
    cyc();
    repeat (4) run_frame();
    run_frame();
    check("pre_rst_state", {7'd0, ball_run, serve_dir, score1, game_over, winner, 2'b0},
          {7'd0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 2'b0});
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst", {3'b0, dut_vec()}, 16'h0000);
    repeat (2) cyc();

    // vsync already high at reset release: no frame until it falls and rises again.
    vsync = 1'b1;
    start = 1'b1;
    reset_n = 1'b1;
    loads_seen = 0;
    repeat (4) cyc();
    check("vs_high_release_noload", 16'(loads_seen), 16'd0);
    vsync = 1'b0;
    repeat (2) cyc();
    vsync = 1'b1;
    repeat (2) cyc();
    vsync = 1'b0;
    repeat (2) cyc();
    check("vs_rearm_load", 16'(loads_seen), 16'd1);
    check("vs_rearm_serve_norun", 16'(ball_run), 16'd0);
    start = 1'b0;

    // Random play with varying frame shapes, occasional resets.
    do_reset();
    for (int f = 0; f < 300; f++) begin
      start = ($urandom_range(0, 3) == 0);
      hi = $urandom_range(1, 3);
      lo = $urandom_range(3, 10);
      if ($urandom_range(0, 79) == 0) reset_n = 1'b0;
      vsync = 1'b1;
      for (int i = 0; i < hi; i++) begin
        miss_left  = ($urandom_range(0, 7) == 0);
        miss_right = ($urandom_range(0, 7) == 0);
        cyc();
        reset_n = 1'b1;
      end
      vsync = 1'b0;
      for (int i = 0; i < lo; i++) begin
        miss_left  = ($urandom_range(0, 7) == 0);
        miss_right = ($urandom_range(0, 7) == 0);
        cyc();
      end
    end
    miss_left  = 1'b0;
    miss_right = 1'b0;
    start      = 1'b0;
    repeat (2) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
